// File: rtl/dmem_bridge.sv
// Data-memory bridge: queues core load/store requests in a small FIFO and replays them
// on a req/gnt/rvalid bus, returning read data to the core with a one-cycle valid pulse.
`timescale 1ns / 1ps
module dmem_bridge #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [XLEN-1:0] mem_addr_i,
    input  logic            mem_read_en_i,
    input  logic            mem_write_en_i,
    input  logic [XLEN-1:0] mem_write_data_i,
    output logic [XLEN-1:0] mem_read_data_o,
    output logic            mem_read_valid_o,
    output logic            stall_o,
    output logic            overflow_o,
    output logic            timeout_o,
    output logic            bus_req_o,
    output logic            bus_we_o,
    output logic [XLEN-1:0] bus_addr_o,
    output logic [XLEN-1:0] bus_wdata_o,
    input  logic            bus_gnt_i,
    input  logic            bus_rvalid_i,
    input  logic [XLEN-1:0] bus_rdata_i
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);
    localparam logic [CntW-1:0] StallC = CntW'(FIFO_DEPTH - 1);
    localparam logic [CntW-1:0] OneC   = CntW'(1);
    localparam logic [15:0]     TmoLast = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitR
    } state_e;

    // Request queue storage
    logic            fifo_we_q    [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_addr_q  [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_wdata_q [FIFO_DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    state_e          state_q, state_d;
    logic [15:0]     tmo_cnt_q, tmo_cnt_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            rvalid_q, rvalid_d;
    logic            overflow_q, overflow_d;
    logic            timeout_q, timeout_d;

    logic            push_req;
    logic            push_ok;
    logic            pop;
    logic            head_we;
    logic [XLEN-1:0] head_addr;
    logic [XLEN-1:0] head_wdata;

    assign push_req   = mem_read_en_i | mem_write_en_i;
    // A pop on the same edge frees a slot, so a full queue can still accept.
    assign push_ok    = push_req & ((count_q < DepthC) | pop);
    assign head_we    = fifo_we_q[rd_ptr_q];
    assign head_addr  = fifo_addr_q[rd_ptr_q];
    assign head_wdata = fifo_wdata_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            fifo_we_q[wr_ptr_q]    <= mem_write_en_i;
            fifo_addr_q[wr_ptr_q]  <= mem_addr_i;
            fifo_wdata_q[wr_ptr_q] <= mem_write_data_i;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + OneC;
            2'b01:   count_d = count_q - OneC;
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q | (push_req & ~push_ok);
    end

    always_comb begin
        state_d     = state_q;
        tmo_cnt_d   = tmo_cnt_q;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        timeout_d   = timeout_q;
        pop         = 1'b0;
        bus_req_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_addr_o  = '0;
        bus_wdata_o = '0;
        case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                bus_req_o   = 1'b1;
                bus_we_o    = head_we;
                bus_addr_o  = head_addr;
                bus_wdata_o = head_wdata;
                if (bus_gnt_i) begin
                    pop = 1'b1;
                    if (head_we) begin
                        state_d = (count_q > OneC) ? StReq : StIdle;
                    end else begin
                        state_d   = StWaitR;
                        tmo_cnt_d = '0;
                    end
                end
            end
            StWaitR: begin
                if (bus_rvalid_i) begin
                    rdata_d  = bus_rdata_i;
                    rvalid_d = 1'b1;
                    state_d  = StIdle;
                end else if (tmo_cnt_q == TmoLast) begin
                    // Abort: hand the core an all-ones word so it is never left waiting.
                    timeout_d = 1'b1;
                    rdata_d   = '1;
                    rvalid_d  = 1'b1;
                    state_d   = StIdle;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= StIdle;
            tmo_cnt_q  <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            tmo_cnt_q  <= tmo_cnt_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
        end
    end

    assign mem_read_data_o  = rdata_q;
    assign mem_read_valid_o = rvalid_q;
    assign stall_o          = (count_q >= StallC);
    assign overflow_o       = overflow_q;
    assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: hand-computed expectations checked cycle by cycle,
// sampled 1ns after each rising edge.
`timescale 1ns / 1ps
module tb_dmem_bridge;

    localparam int XLEN = 32;

    logic            clk_i = 1'b0;
    logic            reset_i;
    logic [XLEN-1:0] mem_addr_i;
    logic            mem_read_en_i;
    logic            mem_write_en_i;
    logic [XLEN-1:0] mem_write_data_i;
    logic [XLEN-1:0] mem_read_data_o;
    logic            mem_read_valid_o;
    logic            stall_o;
    logic            overflow_o;
    logic            timeout_o;
    logic            bus_req_o;
    logic            bus_we_o;
    logic [XLEN-1:0] bus_addr_o;
    logic [XLEN-1:0] bus_wdata_o;
    logic            bus_gnt_i;
    logic            bus_rvalid_i;
    logic [XLEN-1:0] bus_rdata_i;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    dmem_bridge #(
        .XLEN          (32),
        .FIFO_DEPTH    (4),
        .TIMEOUT_CYCLES(255)
    ) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .mem_addr_i      (mem_addr_i),
        .mem_read_en_i   (mem_read_en_i),
        .mem_write_en_i  (mem_write_en_i),
        .mem_write_data_i(mem_write_data_i),
        .mem_read_data_o (mem_read_data_o),
        .mem_read_valid_o(mem_read_valid_o),
        .stall_o         (stall_o),
        .overflow_o      (overflow_o),
        .timeout_o       (timeout_o),
        .bus_req_o       (bus_req_o),
        .bus_we_o        (bus_we_o),
        .bus_addr_o      (bus_addr_o),
        .bus_wdata_o     (bus_wdata_o),
        .bus_gnt_i       (bus_gnt_i),
        .bus_rvalid_i    (bus_rvalid_i),
        .bus_rdata_i     (bus_rdata_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        mem_read_en_i    = 1'b0;
        mem_write_en_i   = 1'b0;
        mem_addr_i       = '0;
        mem_write_data_i = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_i      = 1'b1;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = '0;
        idle_inputs();
        #2;
        check("rst_req", bus_req_o, 0);
        check("rst_valid", mem_read_valid_o, 0);
        check("rst_rdata", mem_read_data_o, 0);
        check("rst_stall", stall_o, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_tmo", timeout_o, 0);
        tick();
        tick();
        reset_i = 1'b0;

        // Single write, immediate grant
        mem_write_en_i   = 1'b1;
        mem_addr_i       = 32'h100;
        mem_write_data_i = 32'hDEADBEEF;
        tick();
        idle_inputs();
        check("w1_req_lat", bus_req_o, 0);
        bus_gnt_i = 1'b1;
        tick();
        check("w1_req", bus_req_o, 1);
        check("w1_we", bus_we_o, 1);
        check("w1_addr", bus_addr_o, 32'h100);
        check("w1_wdata", bus_wdata_o, 32'hDEADBEEF);
        tick();
        bus_gnt_i = 1'b0;
        check("w1_done_req", bus_req_o, 0);
        check("w1_done_addr", bus_addr_o, 0);
        check("w1_no_valid", mem_read_valid_o, 0);
        tick();
        check("w1_empty", bus_req_o, 0);

        // Read with delayed grant and delayed rvalid
        mem_read_en_i = 1'b1;
        mem_addr_i    = 32'h200;
        tick();
        idle_inputs();
        tick();
        check("r1_req_a", bus_req_o, 1);
        check("r1_we", bus_we_o, 0);
        check("r1_addr", bus_addr_o, 32'h200);
        tick();
        check("r1_req_b", bus_req_o, 1);
        tick();
        check("r1_req_c", bus_req_o, 1);
        bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i = 1'b0;
        check("r1_wait_req", bus_req_o, 0);
        tick();
        tick();
        check("r1_no_valid", mem_read_valid_o, 0);
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'h12345678;
        tick();
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = '0;
        check("r1_valid", mem_read_valid_o, 1);
        check("r1_rdata", mem_read_data_o, 32'h12345678);
        tick();
        check("r1_pulse_end", mem_read_valid_o, 0);
        check("r1_rdata_hold", mem_read_data_o, 32'h12345678);

        // Six writes with grant held low: queue fills, last two dropped
        for (int i = 0; i < 6; i++) begin
            mem_write_en_i   = 1'b1;
            mem_addr_i       = 32'h1000 + 32'(i * 4);
            mem_write_data_i = 32'hA0 + 32'(i);
            tick();
            check($sformatf("fill%0d_stall", i), stall_o, (i >= 2) ? 1 : 0);
            check($sformatf("fill%0d_ovf", i), overflow_o, (i >= 4) ? 1 : 0);
        end
        idle_inputs();
        bus_gnt_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d_req", i), bus_req_o, 1);
            check($sformatf("drain%0d_addr", i), bus_addr_o, 32'h1000 + 32'(i * 4));
            check($sformatf("drain%0d_wdata", i), bus_wdata_o, 32'hA0 + 32'(i));
            tick();
        end
        check("drain_idle", bus_req_o, 0);
        check("drain_stall", stall_o, 0);
        check("drain_ovf_sticky", overflow_o, 1);
        bus_gnt_i = 1'b0;
        tick();
        check("drain_no_fifth", bus_req_o, 0);

        // Read that times out, followed by a queued write
        bus_gnt_i     = 1'b1;
        mem_read_en_i = 1'b1;
        mem_addr_i    = 32'h300;
        tick();
        mem_read_en_i    = 1'b0;
        mem_write_en_i   = 1'b1;
        mem_addr_i       = 32'h304;
        mem_write_data_i = 32'h55;
        tick();
        idle_inputs();
        check("t_req", bus_req_o, 1);
        check("t_we", bus_we_o, 0);
        check("t_addr", bus_addr_o, 32'h300);
        tick();
        check("t_wait_req", bus_req_o, 0);
        repeat (254) tick();
        check("t_not_yet", timeout_o, 0);
        check("t_not_yet_valid", mem_read_valid_o, 0);
        tick();
        check("t_flag", timeout_o, 1);
        check("t_valid", mem_read_valid_o, 1);
        check("t_rdata", mem_read_data_o, 32'hFFFFFFFF);
        tick();
        check("t_next_req", bus_req_o, 1);
        check("t_next_we", bus_we_o, 1);
        check("t_next_addr", bus_addr_o, 32'h304);
        check("t_next_wdata", bus_wdata_o, 32'h55);
        check("t_valid_end", mem_read_valid_o, 0);
        tick();
        bus_gnt_i = 1'b0;
        check("t_done", bus_req_o, 0);
        check("t_sticky", timeout_o, 1);

        // Both enables high: write wins
        mem_read_en_i    = 1'b1;
        mem_write_en_i   = 1'b1;
        mem_addr_i       = 32'h40;
        mem_write_data_i = 32'h77;
        tick();
        idle_inputs();
        tick();
        check("both_req", bus_req_o, 1);
        check("both_we", bus_we_o, 1);
        check("both_addr", bus_addr_o, 32'h40);
        bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("both_idle%0d", i), bus_req_o, 0);
            check($sformatf("both_no_valid%0d", i), mem_read_valid_o, 0);
            tick();
        end

        // Reset while waiting on a read with two entries queued
        bus_gnt_i     = 1'b1;
        mem_read_en_i = 1'b1;
        mem_addr_i    = 32'h500;
        tick();
        mem_read_en_i  = 1'b0;
        mem_write_en_i = 1'b1;
        mem_addr_i     = 32'h504;
        tick();
        mem_addr_i = 32'h508;
        tick();
        idle_inputs();
        bus_gnt_i = 1'b0;
        check("rw_wait_req", bus_req_o, 0);
        reset_i = 1'b1;
        #1;
        check("rw_rst_req", bus_req_o, 0);
        check("rw_rst_ovf", overflow_o, 0);
        check("rw_rst_tmo", timeout_o, 0);
        check("rw_rst_rdata", mem_read_data_o, 0);
        check("rw_rst_stall", stall_o, 0);
        tick();
        reset_i      = 1'b0;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hBAD0BAD0;
        tick();
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = '0;
        check("rw_late_valid", mem_read_valid_o, 0);
        check("rw_late_rdata", mem_read_data_o, 0);
        tick();
        check("rw_empty_a", bus_req_o, 0);
        tick();
        check("rw_empty_b", bus_req_o, 0);

        // Reset while a request is on the bus drops it at once
        mem_write_en_i   = 1'b1;
        mem_addr_i       = 32'h600;
        mem_write_data_i = 32'h66;
        tick();
        idle_inputs();
        tick();
        check("rq_req", bus_req_o, 1);
        reset_i = 1'b1;
        #1;
        check("rq_rst_req", bus_req_o, 0);
        check("rq_rst_addr", bus_addr_o, 0);
        tick();
        reset_i = 1'b0;
        tick();
        check("rq_after", bus_req_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Downstream neighbour of the core's memory-access stage. It consumes the core's data-memory request outputs: address, read enable, write enable and write data.
- Queues each request in a small FIFO and replays it on a req/gnt/rvalid handshake data bus.
- Returns read data to the core with a valid pulse.
- Raises a stall hint before the queue fills, and sticky error flags for overflow and bus timeout.

Parameters:
XLEN, 32, data/address width
FIFO_DEPTH, 4, request queue entries (power of 2, >= 2)
TIMEOUT_CYCLES, 255, max cycles in WAIT_R before abort (1..65535)

Ports:
clk_i  input  1  system clock, rising edge
reset_i  input  1  asynchronous, active-high reset
mem_addr_i  input  XLEN  core request address
mem_read_en_i  input  1  core read request
mem_write_en_i  input  1  core write request
mem_write_data_i  input  XLEN  core store data
mem_read_data_o  output  XLEN  returned read data, held until next return
mem_read_valid_o  output  1  one-cycle pulse: mem_read_data_o updated
stall_o  output  1  queue count >= FIFO_DEPTH-1
overflow_o  output  1  sticky: request dropped because queue full
timeout_o  output  1  sticky: read exceeded TIMEOUT_CYCLES
bus_req_o  output  1  bus request, held until bus_gnt_i
bus_we_o  output  1  1 = write, 0 = read
bus_addr_o  output  XLEN  bus address
bus_wdata_o  output  XLEN  bus write data
bus_gnt_i  input  1  bus accepts request this cycle
bus_rvalid_i  input  1  read data valid
bus_rdata_i  input  XLEN  read data

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs 0, FIFO empty, FSM IDLE, timeout counter 0, sticky flags cleared.
  - Reset mid-transaction drops bus_req_o immediately, discards queued and in-flight requests, and produces no read return.
- Enqueue, on each rising edge with mem_read_en_i | mem_write_en_i:
  - Push entry {we, addr, wdata}; we = mem_write_en_i.
  - If both enables are high, the write wins and the read is discarded.
- Push acceptance:
  - Accepted if count < FIFO_DEPTH, or a pop happens on the same edge.
  - Otherwise the request is dropped and overflow_o is set.
- Count arithmetic:
  - count width is clog2(FIFO_DEPTH)+1.
  - Pointers wrap modulo FIFO_DEPTH.
  - A simultaneous push and pop leaves count unchanged.
- stall_o is combinational from count.
- FSM states and transitions:
  - IDLE: if FIFO non-empty, go to REQ.
  - REQ: bus_req_o = 1, and bus_we_o/addr/wdata come from the FIFO head, stable while in REQ. On bus_gnt_i, pop the head:
    - write: go to IDLE, or stay in REQ if another entry is already queued (back-to-back, no bubble);
    - read: go to WAIT_R and clear the timeout counter.
  - WAIT_R: bus_req_o = 0; the counter increments each cycle.
    - On bus_rvalid_i: register bus_rdata_i into mem_read_data_o, pulse mem_read_valid_o in the following cycle, then go to IDLE.
    - If the counter reaches TIMEOUT_CYCLES with no rvalid: set timeout_o, load mem_read_data_o = all ones, pulse mem_read_valid_o, then go to IDLE.
- Bus-side rules:
  - bus_rvalid_i outside WAIT_R is ignored.
  - bus_gnt_i outside REQ is ignored.
  - bus_we_o/addr/wdata are 0 whenever bus_req_o is 0.
- Latency:
  - Request sampled at edge N gives bus_req_o high in cycle N+1 (push at N, IDLE->REQ at N+1 combinationally visible, registered req at N+1).
  - Zero-wait gnt: a write retires at edge N+2.
  - Read with rvalid sampled at edge M gives mem_read_valid_o high during cycle M+1.
- Ordering: requests complete strictly in arrival order. Only one outstanding read at a time.
- Sticky flags clear only on reset.

Test Plan:
- Single write addr 0x100, data 0xDEADBEEF, gnt immediate -> bus_req_o high 1 cycle with we=1, addr=0x100, wdata=0xDEADBEEF; FIFO empty after; no read valid.
- Read 0x200, gnt after 2 cycles, rvalid with rdata 0x12345678 three cycles later -> bus_req_o held 3 cycles, mem_read_data_o=0x12345678, mem_read_valid_o 1-cycle pulse.
- 6 back-to-back writes with gnt held low -> stall_o rises after 3rd push, 5th and 6th dropped, overflow_o=1; release gnt -> exactly 4 writes issued in order.
- Read with rvalid never asserted -> after 255 WAIT_R cycles timeout_o=1, mem_read_data_o=0xFFFFFFFF, valid pulse; next queued write then issues.
- mem_read_en_i and mem_write_en_i both high, addr 0x40 -> single bus write to 0x40, no read return.
- reset_i pulsed while in WAIT_R with 2 entries queued -> bus_req_o=0 immediately, FIFO empty, flags 0; late rvalid after reset produces no mem_read_valid_o.
